// File: rtl/bar_graph_pkg.sv
// Shared types and constants for the bar-graph plotting controller.
// The optional background-clear mode is selected with the BAR_GRAPH_CLEAR_EN macro.
package bar_graph_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_DRAW = 3'd2,
    S_NEXT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [2:0] BG_COLOR = 3'b000;

  // Entry b is the colour of bar b: red, green, blue, yellow.
  localparam logic [3:0][2:0] BAR_COLOR = {3'b110, 3'b001, 3'b010, 3'b100};

  localparam int TILE_PIX     = 4;
  localparam int PIX_PER_TILE = 16;

endpackage

// File: rtl/bar_graph_tile_counter.sv
// Nested bar/tile position counter; presents the position that follows the
// current one and flags the final tile of the final bar.
module bar_graph_tile_counter #(
  parameter int NUM_BARS  = 4,
  parameter int MAX_TILES = 8,
  parameter int BW        = 2,
  parameter int TW        = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear,
  input  logic          advance,
  output logic [BW-1:0] nxt_bar,
  output logic [TW-1:0] nxt_tile,
  output logic          last
);

  logic [BW-1:0] bar_q;
  logic [TW-1:0] tile_q;
  logic          tile_wrap;

  assign tile_wrap = (tile_q == TW'(MAX_TILES - 1));
  assign last      = tile_wrap && (bar_q == BW'(NUM_BARS - 1));

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    nxt_bar  = bar_q;
    nxt_tile = tile_q + TW'(1);
    if (last) begin
      nxt_bar  = '0;
      nxt_tile = '0;
    end else if (tile_wrap) begin
      nxt_bar  = bar_q + BW'(1);
      nxt_tile = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bar_q  <= '0;
      tile_q <= '0;
    end else if (clear) begin
      bar_q  <= '0;
      tile_q <= '0;
    end else if (advance) begin
      bar_q  <= nxt_bar;
      tile_q <= nxt_tile;
    end
  end

endmodule

// File: rtl/bar_graph_control.sv
// Sequencer for the 4x4-tile bar-graph datapath: one LOAD + 16 DRAW + one NEXT per tile.
// Define BAR_GRAPH_CLEAR_EN to paint tiles above each bar in the background colour.
module bar_graph_control
  import bar_graph_pkg::*;
#(
  parameter int NUM_BARS  = 4,
  parameter int MAX_TILES = 8,
  parameter int HW        = 4,
  parameter int BASE_X    = 16,
  parameter int BAR_PITCH = 8,
  parameter int BASE_Y    = 400
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [NUM_BARS*HW-1:0] heights,
  output logic [9:0]             tile_x,
  output logic [8:0]             tile_y,
  output logic [2:0]             color_out,
  output logic                   ld_x,
  output logic                   ld_y,
  output logic                   ld_c,
  output logic                   draw_en,
  output logic                   plot,
  output logic                   busy,
  output logic                   done
);

  localparam int BW = (NUM_BARS  > 1) ? $clog2(NUM_BARS)  : 1;
  localparam int TW = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1;

  state_t        state, nxt_state;
  logic [3:0]    pix_cnt;
  logic [HW-1:0] snap_h [NUM_BARS];
  logic [BW-1:0] nxt_bar, cand_b;
  logic [TW-1:0] nxt_tile, cand_t;
  logic [HW-1:0] cand_h;
  logic          last, accept, advance, load_tile, ld, cand_fill, cand_draw;

  function automatic logic [HW-1:0] clamp_h(input logic [HW-1:0] h);
    return (int'(h) > MAX_TILES) ? HW'(MAX_TILES) : h;
  endfunction

  bar_graph_tile_counter #(
    .NUM_BARS (NUM_BARS),
    .MAX_TILES(MAX_TILES),
    .BW       (BW),
    .TW       (TW)
  ) u_counter (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (accept),
    .advance (advance),
    .nxt_bar (nxt_bar),
    .nxt_tile(nxt_tile),
    .last    (last)
  );

  // The candidate is the tile about to be visited; in IDLE the snapshot is not
  // yet loaded, so the first tile is judged from the live (clamped) height.
  always_comb begin
    if (state == S_IDLE) begin
      cand_b = '0;
      cand_t = '0;
      cand_h = clamp_h(heights[HW-1:0]);
    end else begin
      cand_b = nxt_bar;
      cand_t = nxt_tile;
      cand_h = snap_h[nxt_bar];
    end
  end

  assign cand_fill = int'(cand_t) < int'(cand_h);

`ifdef BAR_GRAPH_CLEAR_EN
  assign cand_draw = 1'b1;
`else
  assign cand_draw = cand_fill;
`endif

  always_comb begin
    nxt_state = state;
    accept    = 1'b0;
    advance   = 1'b0;
    ld        = 1'b0;
    draw_en   = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          nxt_state = cand_draw ? S_LOAD : S_NEXT;
        end
      end
      S_LOAD: begin
        ld        = 1'b1;
        nxt_state = S_DRAW;
      end
      S_DRAW: begin
        draw_en = 1'b1;
        if (pix_cnt == 4'(PIX_PER_TILE - 1)) nxt_state = S_NEXT;
      end
      S_NEXT: begin
        advance = 1'b1;
        if (last)           nxt_state = S_DONE;
        else if (cand_draw) nxt_state = S_LOAD;
        else                nxt_state = S_NEXT;
      end
      S_DONE: begin
        done      = 1'b1;
        nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  assign load_tile = (nxt_state == S_LOAD);
  assign ld_x      = ld;
  assign ld_y      = ld;
  assign ld_c      = ld;
  assign plot      = draw_en;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      pix_cnt <= '0;
    end else begin
      state   <= nxt_state;
      pix_cnt <= (state == S_DRAW) ? pix_cnt + 4'd1 : 4'd0;
    end
  end

  // NOTE: the height snapshot is left without reset; it is always written on start before it is read.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int b = 0; b < NUM_BARS; b++) snap_h[b] <= clamp_h(heights[b*HW +: HW]);
    end
  end

  // Tile geometry and colour are registered on entry to LOAD and held until the next tile.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tile_x    <= '0;
      tile_y    <= '0;
      color_out <= '0;
    end else if (load_tile) begin
      tile_x    <= 10'(BASE_X) + 10'(cand_b) * 10'(BAR_PITCH);
      tile_y    <= 9'(BASE_Y) - 9'(TILE_PIX) * (9'(cand_t) + 9'd1);
      color_out <= cand_fill ? BAR_COLOR[2'(cand_b)] : BG_COLOR;
    end
  end

endmodule

// File: tb/tb_bar_graph_control.sv
// Self-checking bench for bar_graph_control: table of redraw cases scored against a
// tile scoreboard, plus hand-written restart/height-change and mid-draw reset sequences.
module tb_bar_graph_control;

`ifdef BAR_GRAPH_CLEAR_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [15:0] heights;
  logic [9:0]  tile_x;
  logic [8:0]  tile_y;
  logic [2:0]  color_out;
  logic        ld_x, ld_y, ld_c, draw_en, plot, busy, done;

  bar_graph_control dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .heights  (heights),
    .tile_x   (tile_x),
    .tile_y   (tile_y),
    .color_out(color_out),
    .ld_x     (ld_x),
    .ld_y     (ld_y),
    .ld_c     (ld_c),
    .draw_en  (draw_en),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] c;
  } tile_t;

  tile_t sb_q[$];

  typedef struct {
    logic [15:0] h;
    int          restart_cyc;
    int          hchg_cyc;
    int          done_clr;
    int          done_skip;
    int          loads_clr;
    int          loads_skip;
    string       name;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [2:0] exp_color(input int b);
    case (b)
      0:       return 3'b100;
      1:       return 3'b010;
      2:       return 3'b001;
      default: return 3'b110;
    endcase
  endfunction

  // Reference: walk every bar/tile, push each drawn tile's expected LOAD values.
  task automatic build_model(input logic [15:0] h, output int bar1_tiles);
    tile_t tl;
    int    hb;
    bit    fill;
    sb_q.delete();
    bar1_tiles = 0;
    for (int b = 0; b < 4; b++) begin
      hb = int'(h[b*4 +: 4]);
      if (hb > 8) hb = 8;
      for (int t = 0; t < 8; t++) begin
        fill = (t < hb);
        if (CLEAR || fill) begin
          tl.x = 10'(16 + 8*b);
          tl.y = 9'(400 - 4*(t+1));
          tl.c = fill ? exp_color(b) : 3'b000;
          sb_q.push_back(tl);
          if (b == 1) bar1_tiles++;
        end
      end
    end
  endtask

  task automatic run_redraw(input vec_t v);
    int    bar1_tiles, cyc, done_cyc, loads, plots, plots_bar1, busy_gaps, strobe_bad, extra;
    int    exp_done, exp_loads;
    tile_t et, last_t;
    exp_done  = CLEAR ? v.done_clr  : v.done_skip;
    exp_loads = CLEAR ? v.loads_clr : v.loads_skip;
    build_model(v.h, bar1_tiles);
    cyc = 0; done_cyc = -1; loads = 0; plots = 0; plots_bar1 = 0;
    busy_gaps = 0; strobe_bad = 0; extra = 0; last_t = '0;
    @(negedge clk);
    heights = v.h;
    start   = 1'b1;
    while (done_cyc < 0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == v.restart_cyc) start = 1'b1;
      if (cyc == v.restart_cyc + 1) start = 1'b0;
      if (cyc == v.hchg_cyc) heights = ~v.h;
      if (!busy) busy_gaps++;
      if (plot !== draw_en) strobe_bad++;
      if (ld_x || ld_y || ld_c) begin
        if (!(ld_x && ld_y && ld_c) || plot) strobe_bad++;
        loads++;
        if (sb_q.size() == 0) extra++;
        else begin
          et = sb_q.pop_front();
          check({v.name, " tile_x"}, 32'(tile_x), 32'(et.x));
          check({v.name, " tile_y"}, 32'(tile_y), 32'(et.y));
          check({v.name, " color"},  32'(color_out), 32'(et.c));
          last_t = et;
        end
      end
      if (plot) begin
        plots++;
        if (tile_x >= 10'd24 && tile_x <= 10'd27) plots_bar1++;
      end
      if (done) done_cyc = cyc;
    end
    check({v.name, " done cycle"}, 32'(done_cyc), 32'(exp_done));
    check({v.name, " load cycles"}, 32'(loads), 32'(exp_loads));
    check({v.name, " plot cycles"}, 32'(plots), 32'(16 * exp_loads));
    check({v.name, " bar1 plots"}, 32'(plots_bar1), 32'(16 * bar1_tiles));
    check({v.name, " busy gaps"}, 32'(busy_gaps), 32'd0);
    check({v.name, " strobe errors"}, 32'(strobe_bad + extra), 32'd0);
    check({v.name, " tiles left"}, 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    check({v.name, " done width"}, 32'(done), 32'd0);
    check({v.name, " idle busy"}, 32'(busy), 32'd0);
    if (loads > 0) begin
      check({v.name, " hold x"}, 32'(tile_x), 32'(last_t.x));
      check({v.name, " hold y"}, 32'(tile_y), 32'(last_t.y));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " tile_x"},  32'(tile_x), 32'd0);
    check({tag, " tile_y"},  32'(tile_y), 32'd0);
    check({tag, " color"},   32'(color_out), 32'd0);
    check({tag, " ld"},      32'({ld_x, ld_y, ld_c}), 32'd0);
    check({tag, " draw_en"}, 32'(draw_en), 32'd0);
    check({tag, " plot"},    32'(plot), 32'd0);
    check({tag, " busy"},    32'(busy), 32'd0);
    check({tag, " done"},    32'(done), 32'd0);
  endtask

  initial begin
    int bar1_tiles;
    // heights packs bar b in bits [4b+3:4b]; 16'h1802 is bars {2,0,8,1}.
    vecs[0] = '{16'h1802, 0,  0,  577, 220, 32, 11, "mixed"};
    vecs[1] = '{16'h9802, 0,  0,  577, 339, 32, 18, "clamp9"};
    vecs[2] = '{16'h0000, 0,  0,  577, 33,  32, 0,  "all_zero"};
    vecs[3] = '{16'h1111, 0,  0,  577, 101, 32, 4,  "ones"};
    vecs[4] = '{16'hFFFF, 0,  0,  577, 577, 32, 32, "all_15"};
    vecs[5] = '{16'h1802, 50, 60, 577, 220, 32, 11, "restart_hchg"};

    resetn  = 1'b0;
    start   = 1'b0;
    heights = '0;
    #1;
    check_all_zero("reset");
    #20;
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("idle without start busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) run_redraw(vecs[i]);

    // Reset asserted mid-DRAW: everything drops at once, then a fresh redraw repeats case 1.
    build_model(16'h1802, bar1_tiles);
    @(negedge clk);
    heights = 16'h1802;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    check("pre-reset draw_en", 32'(draw_en), 32'd1);
    resetn = 1'b0;
    #1;
    check_all_zero("async reset");
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("post-reset busy", 32'(busy), 32'd0);
    run_redraw(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
